adder_tree_arbiter: RTL and testbench
=====================================

# adder_tree_arbiter

Round-robin scheduler that shares one pipelined `adder_tree` instance between `NUM_REQ` kernel requesters, such as the Sobel-X and Sobel-Y window generators. It accepts at most one operand vector per cycle and drives the tree input. A tag pipeline matched to the tree latency routes each sum back to the requester that issued it. The block also sequences the tree's mandatory post-reset warm-up and provides a flush/drain handshake for frame boundaries.

## Interface
- `NUM_REQ`, 2, number of requesters (≥1).
- `INPUT_NUM`, 18, operands per vector; must match the tree.
- `IN_WIDTH`, 12, operand width (signed); must match the tree.
- `OUT_WIDTH`, `IN_WIDTH + $clog2(INPUT_NUM)`, tree result width.
- Localparam `TREE_LAT = $clog2(INPUT_NUM) + 1`: tree input-to-output cycles (6 at defaults).
- Ports:
  - `clk` in 1: the single clock.
  - `rst_n` in 1: asynchronous, active-low reset; shared with the tree instance.
  - `req_valid` in `NUM_REQ`: per-requester vector valid.
  - `req_data` in `NUM_REQ*INPUT_NUM*IN_WIDTH`: requester i occupies slice [(i+1)*INPUT_NUM*IN_WIDTH-1 -: INPUT_NUM*IN_WIDTH].
  - `req_ready` out `NUM_REQ`: one-hot grant, or zero.
  - `tree_din` out `INPUT_NUM*IN_WIDTH`: registered operand vector to the tree.
  - `tree_dout` in `OUT_WIDTH`: tree result (signed).
  - `rsp_valid` out `NUM_REQ`: one-hot single-cycle result strobe.
  - `rsp_data` out `OUT_WIDTH`: registered result.
  - `flush_req` in 1: level request to drain the pipeline.
  - `flush_done` out 1: single-cycle pulse when the drain completes.
  - `busy` out 1: high in INIT or DRAIN.

## Operation
- FSM states: INIT, RUN, DRAIN.
  - Reset enters INIT, with counter = 0.
  - INIT → RUN after TREE_LAT+1 cycles. While in INIT, `tree_din` is driven to 0 so that every tree stage holds 0.
  - RUN → DRAIN when `flush_req` = 1.
  - DRAIN → RUN in the cycle after the in-flight count reaches 0. `flush_done` pulses in that transition cycle.
- Arbitration happens only in RUN with `flush_req` = 0.
  - Priority starts at (last_grant+1) mod NUM_REQ and searches upward, wrapping.
  - `last_grant` resets to NUM_REQ-1, so requester 0 wins first.
  - `req_ready[i]` = 1 only for the chosen i that has `req_valid[i]` = 1. Ready depends combinationally on valid.
  - A transfer occurs when valid & ready are both high. `last_grant` updates only on a transfer.
- Datapath:
  - On a transfer, the granted slice is registered into `tree_din`.
  - With no transfer, `tree_din` holds its previous value. Its contents are ignored because the tag is invalid.
- Tag pipeline:
  - The tag shift register has depth TREE_LAT+1 and entries of {valid, id}.
  - Stage 0 is loaded on each transfer; otherwise it loads {0,x}.
  - The last stage aligns with `tree_dout`. When its valid bit is set, `rsp_data` <= `tree_dout` and `rsp_valid[id]` <= 1 on the next edge.
- In-flight count:
  - Counts tag-pipeline valid entries plus the output register.
  - Its width is `$clog2(TREE_LAT+3)`.
  - It increments on a transfer and decrements on a response; both in the same cycle leaves it unchanged.
- There is no response backpressure. Requesters must always accept `rsp_valid`.
- Boundaries:
  - `flush_req` and `req_valid` high in the same RUN cycle: flush wins and no grant is issued.
  - `flush_req` held high after `flush_done`: DRAIN is re-entered on the next cycle. A second `flush_done` follows after 1 cycle if the pipe is empty.
  - NUM_REQ = 1: no rotation, and requester 0 is always eligible.
  - All requesters valid: a strict rotation of 0,1,…,NUM_REQ-1 with one grant per cycle.
- Reset mid-operation:
  - All tags and the in-flight count clear.
  - Pending results are discarded, and no `rsp_valid` is issued for them.
  - The FSM re-enters INIT.

## Timing
- Reset values:
  - `req_ready` = 0, `tree_din` = 0, `rsp_valid` = 0, `rsp_data` = 0.
  - `flush_done` = 0, `busy` = 1, state INIT, `last_grant` = NUM_REQ-1.
- First possible grant: cycle TREE_LAT+1 after `rst_n` deasserts (cycle 7 at defaults).
- Accept-to-response latency: a transfer in cycle t gives `rsp_valid` in cycle t+TREE_LAT+2 (t+8 at defaults).
- Throughput: 1 vector/cycle sustained. Response order equals grant order.
- `flush_done`: asserted no earlier than the cycle after the last outstanding `rsp_valid`. `busy` drops in the same cycle as the `flush_done` pulse.

## Test plan
- Warm-up:
  - Stimulus: release `rst_n` with `req_valid[0]` = 1 held.
  - Response: `req_ready` = 0 for cycles 0–6 and `busy` = 1; first grant in cycle 7.
  - Check: no `rsp_valid` before cycle 15.
- Single request:
  - Stimulus: requester 1 sends all operands = +1, with the tree in normal mode.
  - Response: `rsp_valid` = 2'b10 and `rsp_data` = 18 exactly 8 cycles after the transfer.
- Round robin:
  - Stimulus: both requesters valid continuously; requester 0 sends all operands = 2, requester 1 sends all = -3.
  - Response: grants alternate 0,1,0,1. Responses alternate 36 and -54 with matching one-hot `rsp_valid`.
- Flush:
  - Stimulus: 3 back-to-back transfers, then `flush_req` pulse (1 cycle) while `req_valid` stays high.
  - Response: no grants during DRAIN, 3 responses delivered, then `flush_done` for 1 cycle. Grants resume the next cycle.
- Reset mid-flight:
  - Stimulus: assert `rst_n` low 2 cycles after 4 transfers, then release.
  - Response: zero `rsp_valid` pulses for the lost vectors, and the INIT sequence repeats.
- Saturation extreme:
  - Stimulus: all operands = -2048.
  - Response: `rsp_data` = -36864, with Sobel-mode tree output 36864 in 17 bits.

Source files
------------

// File: rtl/adder_tree_arbiter.sv
// Round-robin front end that time-shares one pipelined adder tree between NUM_REQ requesters.
// Sequences tree warm-up after reset, routes each sum back by tag, and drains on flush.
module adder_tree_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned INPUT_NUM = 18,
  parameter int unsigned IN_WIDTH  = 12,
  parameter int unsigned OUT_WIDTH = IN_WIDTH + $clog2(INPUT_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*INPUT_NUM*IN_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [INPUT_NUM*IN_WIDTH-1:0]         tree_din,
  input  logic [OUT_WIDTH-1:0]                  tree_dout,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [OUT_WIDTH-1:0]                  rsp_data,
  input  logic                                  flush_req,
  output logic                                  flush_done,
  output logic                                  busy
);

  localparam int unsigned TREE_LAT = $clog2(INPUT_NUM) + 1;
  localparam int unsigned DEPTH    = TREE_LAT + 1;
  localparam int unsigned VEC_W    = INPUT_NUM * IN_WIDTH;
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W    = $clog2(TREE_LAT + 3);
  localparam int unsigned INIT_W   = $clog2(TREE_LAT + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_e;

  state_e                      state_q, state_d;
  logic [INIT_W-1:0]           init_cnt_q, init_cnt_d;
  logic [ID_W-1:0]             last_grant_q, last_grant_d;
  logic [VEC_W-1:0]            tree_din_q, tree_din_d;
  logic [DEPTH-1:0]            tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic [CNT_W-1:0]            inflight_q, inflight_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [OUT_WIDTH-1:0]        rsp_data_q, rsp_data_d;
  logic                        flush_done_q, flush_done_d;
  logic                        busy_q, busy_d;

  logic                        grant_any;
  logic [ID_W-1:0]             grant_id;
  logic                        rsp_out;

  // Round-robin pick: first valid above last_grant, then wrap to the lowest index.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    if (state_q == S_RUN && !flush_req) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i] && (ID_W'(i) > last_grant_q)) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i] && (ID_W'(i) <= last_grant_q)) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_any && (grant_id == ID_W'(i));
    end
  end

  assign rsp_out = |rsp_valid_q;

  // Next-state, datapath, tag pipeline and in-flight accounting.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    last_grant_d = last_grant_q;
    tree_din_d   = tree_din_q;
    tag_vld_d    = {tag_vld_q[DEPTH-2:0], grant_any};
    tag_id_d     = {tag_id_q[DEPTH-2:0], grant_id};
    inflight_d   = inflight_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    flush_done_d = 1'b0;
    busy_d       = 1'b1;

    case (state_q)
      S_INIT: begin
        // Zero operands flush every tree stage before real traffic.
        tree_din_d = '0;
        if (init_cnt_q == INIT_W'(TREE_LAT)) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      S_RUN: begin
        if (flush_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight_q == '0) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase

    if (grant_any) begin
      last_grant_d = grant_id;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_id == ID_W'(i)) tree_din_d = req_data[i*VEC_W +: VEC_W];
      end
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = tag_vld_q[DEPTH-1] && (tag_id_q[DEPTH-1] == ID_W'(i));
    end
    if (tag_vld_q[DEPTH-1]) rsp_data_d = tree_dout;

    case ({grant_any, rsp_out})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    // Done is raised one cycle ahead so it lines up with the DRAIN->RUN transition cycle.
    flush_done_d = (state_d == S_DRAIN) && (inflight_d == '0);
    busy_d       = (state_d != S_RUN) && !flush_done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      tree_din_q   <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      inflight_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      last_grant_q <= last_grant_d;
      tree_din_q   <= tree_din_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      inflight_q   <= inflight_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      flush_done_q <= flush_done_d;
      busy_q       <= busy_d;
    end
  end

  assign tree_din   = tree_din_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign flush_done = flush_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Bench for adder_tree_arbiter: a behavioural pipelined adder tree plus directed vectors
// whose expected responses are queued at issue time and matched by a separate monitor.
module tb_adder_tree_arbiter;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned INPUT_NUM = 18;
  localparam int unsigned IN_WIDTH  = 12;
  localparam int unsigned OUT_WIDTH = IN_WIDTH + $clog2(INPUT_NUM);
  localparam int unsigned TREE_LAT  = $clog2(INPUT_NUM) + 1;
  localparam int unsigned VEC_W     = INPUT_NUM * IN_WIDTH;
  localparam int          RSP_LAT   = 8;

  logic                         clk;
  logic                         rst_n;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*VEC_W-1:0]     req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [VEC_W-1:0]             tree_din;
  logic [OUT_WIDTH-1:0]         tree_dout;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [OUT_WIDTH-1:0]         rsp_data;
  logic                         flush_req;
  logic                         flush_done;
  logic                         busy;

  adder_tree_arbiter #(
    .NUM_REQ(NUM_REQ), .INPUT_NUM(INPUT_NUM), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tree_din(tree_din), .tree_dout(tree_dout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush_req(flush_req),
    .flush_done(flush_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural tree: TREE_LAT register stages from tree_din to tree_dout.
  logic signed [OUT_WIDTH-1:0] tree_pipe [TREE_LAT];

  function automatic logic signed [OUT_WIDTH-1:0] vec_sum(input logic [VEC_W-1:0] v);
    logic signed [OUT_WIDTH-1:0] s;
    logic signed [IN_WIDTH-1:0]  op;
    s = '0;
    for (int i = 0; i < int'(INPUT_NUM); i++) begin
      op = v[i*IN_WIDTH +: IN_WIDTH];
      s  = s + OUT_WIDTH'(op);
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TREE_LAT); i++) tree_pipe[i] <= '0;
    end else begin
      tree_pipe[0] <= vec_sum(tree_din);
      for (int i = 1; i < int'(TREE_LAT); i++) tree_pipe[i] <= tree_pipe[i-1];
    end
  end
  assign tree_dout = tree_pipe[TREE_LAT-1];

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int id;
    int data;
    int at;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [VEC_W-1:0] vec_all(input int v);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < int'(INPUT_NUM); i++) r[i*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(v);
    return r;
  endfunction

  // One cycle: drive inputs just after the edge, check at the falling edge, queue the response.
  task automatic step(input logic [1:0] valid, input int v0, input int v1, input logic flush,
                      input logic [1:0] exp_rdy, input logic exp_busy, input logic exp_fd,
                      input bit push);
    int id;
    req_valid = valid;
    req_data  = {vec_all(v1), vec_all(v0)};
    flush_req = flush;
    @(negedge clk);
    chk("req_ready", longint'(req_ready), longint'(exp_rdy));
    chk("busy", longint'(busy), longint'(exp_busy));
    chk("flush_done", longint'(flush_done), longint'(exp_fd));
    if (push && exp_rdy != 2'b00) begin
      id = (exp_rdy == 2'b10) ? 1 : 0;
      sb.push_back('{id: id, data: int'(INPUT_NUM) * ((id == 1) ? v1 : v0), at: cyc + RSP_LAT});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset(input int v0);
    rst_n     = 1'b0;
    req_valid = 2'b01;
    req_data  = {vec_all(0), vec_all(v0)};
    flush_req = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_tree_din_ones", longint'($countones(tree_din)), 0);
    chk("rst_rsp_valid", longint'(rsp_valid), 0);
    chk("rst_rsp_data", longint'(rsp_data), 0);
    chk("rst_flush_done", longint'(flush_done), 0);
    chk("rst_busy", longint'(busy), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic warmup(input int v0);
    for (int i = 0; i < 7; i++) step(2'b01, v0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b01, v0, 0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    flush_req = 1'b0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (sb.size() != 0 && sb[0].at < cyc) begin
              e = sb.pop_front();
              chk("rsp_missing_at_cycle", longint'(cyc), longint'(e.at));
            end
            if (rsp_valid != '0) begin
              if (sb.size() == 0) begin
                chk("rsp_unexpected", longint'(rsp_valid), 0);
              end else begin
                e = sb.pop_front();
                chk("rsp_valid", longint'(rsp_valid), longint'(1) << e.id);
                chk("rsp_data", longint'($signed(rsp_data)), longint'(e.data));
                chk("rsp_cycle", longint'(cyc), longint'(e.at));
              end
            end
          end
        end
      end
    join_none

    // Warm-up: grant only in cycle 7, response in cycle 15.
    apply_reset(5);
    warmup(5);
    idle(10);

    // Single request from requester 1, all +1 -> 18.
    step(2'b10, 0, 1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    idle(10);

    // Round robin 0,1,0,1 with 36 / -54.
    for (int i = 0; i < 2; i++) begin
      step(2'b11, 2, -3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
      step(2'b11, 2, -3, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    end
    idle(10);

    // Flush: three transfers, flush wins over valid, drain, done, grant resumes.
    step(2'b11, 2, -3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    step(2'b11, 2, -3, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    step(2'b11, 2, -3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    step(2'b11, 2, -3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(2'b11, 2, -3, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b11, 2, -3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(2'b11, 2, -3, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    idle(10);

    // Flush held high with an empty pipe: done, re-enter drain, done again.
    step(2'b11, 2, -3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b11, 2, -3, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    step(2'b11, 2, -3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b11, 2, -3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(2'b00, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Reset mid-flight: four lost transfers must never respond.
    step(2'b11, 7, 9, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b11, 7, 9, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    step(2'b11, 7, 9, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b11, 7, 9, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(2);
    apply_reset(-2048);

    // Warm-up repeats; most negative operands -> -36864.
    warmup(-2048);
    idle(12);

    chk("scoreboard_empty", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
